mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, data width of every data port.
REQ-002 Parameter: ADDR_W, default 32, address width of every address port.
REQ-003 Parameter: STARVE_MAX, default 4, max consecutive contested grants to port 0 before port 1 is forced (legal range 1..15).
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: p0_req / p1_req  in  1  requester n has a valid access this cycle.
REQ-007 Ports: p0_wr / p1_wr  in  1  1 = write, 0 = read.
REQ-008 Ports: p0_addr / p1_addr  in  ADDR_W  access address.
REQ-009 Ports: p0_wdata / p1_wdata  in  DATA_W  write data.
REQ-010 Ports: p0_gnt / p1_gnt  out  1  access accepted this cycle; requester holds req/wr/addr/wdata stable until gnt.
REQ-011 Ports: p0_rvalid / p1_rvalid  out  1  read data valid for requester n.
REQ-012 Ports: p0_rdata / p1_rdata  out  DATA_W  read data.
REQ-013 Ports: MemRd, MemWr  out  1  memory read/write strobes.
REQ-014 Ports: Address  out  ADDR_W; WrData  out  DATA_W; RdData  in  DATA_W  memory port (synchronous read, data valid the cycle after MemRd).

Function
REQ-015 Grant decision is combinational from current req inputs and registered state; at most one gnt high per cycle.
REQ-016 Only p0_req: grant p0. Only p1_req: grant p1. Neither: no grant, MemRd=MemWr=0, Address=0, WrData=0.
REQ-017 Both requesting (contested): grant p0 unless starve_cnt == STARVE_MAX, then grant p1.
REQ-018 starve_cnt (4-bit register): +1 on each contested cycle granted to p0; cleared on any p1 grant; holds otherwise; never exceeds STARVE_MAX.
REQ-019 Granted cycle drives MemRd = ~wr, MemWr = wr, Address/WrData from the granted port, same cycle as gnt.
REQ-020 Writes complete in the grant cycle; no response.
REQ-021 Reads pipelined: grant in cycle N -> rvalid for the same port in cycle N+1 with rdata = RdData; new grant allowed in N+1 (one access per cycle throughput).
REQ-022 Return routing via registered rd_pend (1 bit) and rd_id (1 bit) captured at grant; rvalid of the other port stays 0.
REQ-023 rdata of a port not returning data is 0.
REQ-024 Granted write immediately after granted read to same address: read returns pre-write data (order preserved by memory).
REQ-025 Requester dropping req without gnt: legal, no memory access, starve_cnt unaffected unless contested that cycle.

Reset
REQ-026 While rst high (asynchronous): starve_cnt=0, rd_pend=0, rd_id=0; all gnt, rvalid, MemRd, MemWr low; Address, WrData, rdata 0.
REQ-027 Reset asserted during a pending read: the return is discarded, no rvalid after release.
REQ-028 First rising clk after rst deasserts evaluates requests normally.

Verification
REQ-029 Single read: p0 read addr 0x10, memory holds 0xDEADBEEF -> p0_gnt cycle N, MemRd=1 Address=0x10; p0_rvalid=1 p0_rdata=0xDEADBEEF cycle N+1.
REQ-030 Contention with STARVE_MAX=4: p0 and p1 request continuously -> grant sequence p0,p0,p0,p0,p1, repeating; no p1 wait exceeds 5 cycles.
REQ-031 Back-to-back reads p1 addr 0x4 then p0 addr 0x8 -> rvalid p1 in N+1, p0 in N+2, each with correct data, no cross-port leakage.
REQ-032 Write then read: p1 writes 0x12345678 to 0x20, p0 reads 0x20 next cycle -> p0_rdata=0x12345678.
REQ-033 Reset mid-read: p0 read granted, rst pulsed before next edge -> no p0_rvalid, starve_cnt=0, all outputs 0.
REQ-034 Idle: no requests -> MemRd=MemWr=0, Address=0, all gnt/rvalid 0 for 10 cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_wr;
  logic              p1_wr;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_gnt;
  logic              p1_gnt;
  logic              p0_rvalid;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              MemRd;
  logic              MemWr;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] RdData;

  modport slave (
    input  p0_req, p1_req, p0_wr, p1_wr, p0_addr, p1_addr, p0_wdata, p1_wdata, RdData,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           MemRd, MemWr, Address, WrData
  );

  modport master (
    output p0_req, p1_req, p0_wr, p1_wr, p0_addr, p1_addr, p0_wdata, p1_wdata, RdData,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           MemRd, MemWr, Address, WrData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port 0 has priority, port 1 is forced after STARVE_MAX
// consecutive contested losses. Reads return one cycle after grant, routed by rd_id.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_id_q, rd_id_d;
  logic              gnt0, gnt1, contested, rd_gnt, wr_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  always_comb begin
    contested = bus.p0_req & bus.p1_req;
    // Grants are masked by rst so every strobe is quiet while reset is held.
    gnt0      = ~rst & bus.p0_req & ~(bus.p1_req & (starve_cnt_q == CNT_MAX));
    gnt1      = ~rst & bus.p1_req & ~gnt0;
    rd_gnt    = (gnt0 & ~bus.p0_wr) | (gnt1 & ~bus.p1_wr);
    wr_gnt    = (gnt0 &  bus.p0_wr) | (gnt1 &  bus.p1_wr);
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt0) begin
      addr_sel  = bus.p0_addr;
      wdata_sel = bus.p0_wdata;
    end else if (gnt1) begin
      addr_sel  = bus.p1_addr;
      wdata_sel = bus.p1_wdata;
    end

    starve_cnt_d = starve_cnt_q;
    if (gnt1)
      starve_cnt_d = '0;
    else if (gnt0 && contested)
      starve_cnt_d = starve_cnt_q + 4'd1;

    rd_pend_d = rd_gnt;
    rd_id_d   = rd_gnt ? gnt1 : rd_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_id_q      <= rd_id_d;
    end
  end

  assign bus.p0_gnt  = gnt0;
  assign bus.p1_gnt  = gnt1;
  assign bus.MemRd   = rd_gnt;
  assign bus.MemWr   = wr_gnt;
  assign bus.Address = addr_sel;
  assign bus.WrData  = wdata_sel;

  // Read return: memory data is steered to the port captured at grant time.
  assign bus.p0_rvalid = rd_pend_q & ~rd_id_q;
  assign bus.p1_rvalid = rd_pend_q &  rd_id_q;
  assign bus.p0_rdata  = bus.p0_rvalid ? bus.RdData : '0;
  assign bus.p1_rdata  = bus.p1_rvalid ? bus.RdData : '0;

endmodule
